// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM command encodings, bank states and default timings
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_ACT  = 2'b01,
        CMD_RDWR = 2'b10,
        CMD_PRE  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVATING,
        ST_ACTIVE,
        ST_PRECHARGING
    } bank_state_e;

    localparam int DEF_T_RCD = 3;
    localparam int DEF_T_CL  = 2;
    localparam int DEF_T_RP  = 2;

endpackage

// File: rtl/dram_bank_responder_if.sv
// rtl/dram_bank_responder_if.sv - command/response bundle between dram_ctrl and one bank
interface dram_bank_responder_if #(
    parameter int DATA_WIDTH   = 1,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8
);
    logic [1:0]                        cmd;
    logic [$clog2(NUM_OF_BANKS)-1:0]   cs;
    logic                              rw;
    logic [$clog2(NUM_OF_ROWS)-1:0]    row_addr;
    logic [$clog2(NUM_OF_COLS)-1:0]    col_addr;
    logic [DATA_WIDTH-1:0]             wr_data;
    logic [DATA_WIDTH-1:0]             rd_data;
    logic                              rd_valid;
    logic                              busy;
    logic                              err;

    modport master (
        output cmd, cs, rw, row_addr, col_addr, wr_data,
        input  rd_data, rd_valid, busy, err
    );

    modport slave (
        input  cmd, cs, rw, row_addr, col_addr, wr_data,
        output rd_data, rd_valid, busy, err
    );
endinterface

// File: rtl/dram_rd_pipe.sv
// rtl/dram_rd_pipe.sv - fixed CAS-latency shift register for read valid and data
module dram_rd_pipe #(
    parameter int DATA_WIDTH = 1,
    parameter int T_CL       = 2
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic                  valid_sr [T_CL];
    logic [DATA_WIDTH-1:0] data_sr  [T_CL];

    // Data is zeroed on entry when not valid so the output reads 0 between pulses.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < T_CL; i++) begin
                valid_sr[i] <= 1'b0;
                data_sr[i]  <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            data_sr[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < T_CL; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                data_sr[i]  <= data_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[T_CL-1];
    assign out_data  = data_sr[T_CL-1];
endmodule

// File: rtl/dram_bank_responder.sv
// rtl/dram_bank_responder.sv - one DRAM bank: open-row FSM, timing counters, array, read pipe
module dram_bank_responder
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int BANK_ID      = 0,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_CL         = DEF_T_CL,
    parameter int T_RP         = DEF_T_RP
) (
    input  logic                 clk,
    input  logic                 rst_b,
    dram_bank_responder_if.slave bus
);
    localparam int CS_W    = $clog2(NUM_OF_BANKS);
    localparam int ROW_W   = $clog2(NUM_OF_ROWS);
    localparam int CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);

    bank_state_e           state;
    logic [CNT_W-1:0]      cnt;
    logic [ROW_W-1:0]      open_row;
    logic                  busy_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [NUM_OF_ROWS][NUM_OF_COLS];

    logic sel, is_act, is_rdwr, is_pre, is_any;
    logic rd_fire, wr_fire;

    assign sel     = (bus.cs == CS_W'(BANK_ID));
    assign is_act  = sel && (bus.cmd == CMD_ACT);
    assign is_rdwr = sel && (bus.cmd == CMD_RDWR);
    assign is_pre  = sel && (bus.cmd == CMD_PRE);
    assign is_any  = sel && (bus.cmd != CMD_NOP);
    assign rd_fire = (state == ST_ACTIVE) && is_rdwr &&  bus.rw;
    assign wr_fire = (state == ST_ACTIVE) && is_rdwr && !bus.rw;

    // The counter holds remaining wait cycles; expiry is taken at 1 so the
    // next command slot lands exactly T_RCD / T_RP cycles after the command.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            open_row <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_act) begin
                        open_row <= bus.row_addr;
                        if (T_RCD > 1) begin
                            state  <= ST_ACTIVATING;
                            cnt    <= RCD_LOAD;
                            busy_q <= 1'b1;
                        end else begin
                            state <= ST_ACTIVE;
                        end
                    end else if (is_rdwr) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ACTIVATING: begin
                    err_q <= is_any;
                    if (cnt <= 1) begin
                        state  <= ST_ACTIVE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (is_act) begin
                        err_q <= 1'b1;
                    end else if (is_pre) begin
                        if (T_RP > 1) begin
                            state  <= ST_PRECHARGING;
                            cnt    <= RP_LOAD;
                            busy_q <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PRECHARGING: begin
                    err_q <= is_any;
                    if (cnt <= 1) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[open_row][bus.col_addr] <= bus.wr_data;
        end
    end

    dram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .T_CL       (T_CL)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (rd_fire),
        .in_data   (mem[open_row][bus.col_addr]),
        .out_valid (bus.rd_valid),
        .out_data  (bus.rd_data)
    );

    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_dram_bank_responder.sv
// tb/tb_dram_bank_responder.sv - scoreboard bench for dram_bank_responder
module tb_dram_bank_responder;
    import dram_pkg::*;

    localparam int DW = 1, NB = 8, NR = 128, NC = 8, BID = 2;
    localparam int TRCD = 3, TCL = 2, TRP = 2;
    localparam logic [2:0] MY_CS    = 3'(BID);
    localparam logic [2:0] OTHER_CS = 3'(BID + 1);

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    dram_bank_responder_if #(.DATA_WIDTH(DW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus_if ();

    dram_bank_responder #(
        .DATA_WIDTH(DW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
        .BANK_ID(BID), .T_RCD(TRCD), .T_CL(TCL), .T_RP(TRP)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every read response must match the head of the scoreboard in data and cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus_if.rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: rd_valid=1 at cycle %0d, required no read pending", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus_if.rd_data !== mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL sb_read: got data %b at cycle %0d, required data %b at cycle %0d",
                                 bus_if.rd_data, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end else if (bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== '0) begin
                errors++;
                $display("FAIL idle_out: rd_valid=%b rd_data=%b at cycle %0d, required 0/0",
                         bus_if.rd_valid, bus_if.rd_data, cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [2:0] cs_v, input logic rw_v,
                         input logic [6:0] row, input logic [2:0] col, input logic wd);
        bus_if.cmd      = c;
        bus_if.cs       = cs_v;
        bus_if.rw       = rw_v;
        bus_if.row_addr = row;
        bus_if.col_addr = col;
        bus_if.wr_data  = wd;
        @(posedge clk);
        #1;
        bus_if.cmd = CMD_NOP;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(CMD_NOP, MY_CS, 1'b0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic act(input logic [6:0] row);
        issue(CMD_ACT, MY_CS, 1'b0, row, 3'd0, 1'b0);
    endtask

    task automatic pre();
        issue(CMD_PRE, MY_CS, 1'b0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] col, input logic d);
        issue(CMD_RDWR, MY_CS, 1'b0, 7'd0, col, d);
    endtask

    task automatic rd(input logic [2:0] col, input bit expect_data, input logic d);
        exp_t e;
        if (expect_data) begin
            e.data = d;
            e.cyc  = cyc + TCL;
            sb.push_back(e);
        end
        issue(CMD_RDWR, MY_CS, 1'b1, 7'd0, col, 1'b0);
    endtask

    task automatic test_reset();
        bus_if.cmd = CMD_NOP; bus_if.cs = '0; bus_if.rw = 1'b0;
        bus_if.row_addr = '0; bus_if.col_addr = '0; bus_if.wr_data = '0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd_valid=%b rd_data=%b busy=%b err=%b, required all 0",
                     bus_if.rd_valid, bus_if.rd_data, bus_if.busy, bus_if.err);
        end
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        act(7'd5);
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_t1: busy=%b err=%b, required 1/0", bus_if.busy, bus_if.err);
        end
        nop(1);
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_t2: busy=%b, required 1", bus_if.busy);
        end
        nop(1);
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_t3: busy=%b, required 0", bus_if.busy);
        end
        wr(3'd3, 1'b1);
        checks++;
        if (bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_wr_err: err=%b, required 0", bus_if.err);
        end
        rd(3'd3, 1'b1, 1'b1);
        nop(3);
        pre();
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_busy: busy=%b, required 1", bus_if.busy);
        end
        nop(1);
    endtask

    task automatic test_rd_in_trcd();
        act(7'd0);
        rd(3'd0, 1'b0, 1'b0);
        checks++;
        if (bus_if.err !== 1'b1) begin
            errors++;
            $display("FAIL trcd_err: err=%b, required 1", bus_if.err);
        end
        nop(1);
        checks++;
        if (bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL trcd_err_pulse: err=%b, required 0", bus_if.err);
        end
        nop(2);
        pre();
        nop(1);
    endtask

    task automatic test_back_to_back();
        act(7'd7);
        nop(2);
        for (int c = 0; c < 8; c++) wr(3'(c), (c % 2) == 0);
        for (int c = 0; c < 8; c++) rd(3'(c), 1'b1, (c % 2) == 0);
        nop(TCL + 1);
        pre();
        nop(1);
    endtask

    task automatic test_rd_then_pre();
        act(7'd1);
        nop(2);
        wr(3'd2, 1'b1);
        rd(3'd2, 1'b1, 1'b1);
        pre();
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL rdpre_busy: busy=%b, required 1", bus_if.busy);
        end
        act(7'd1);
        checks++;
        if (bus_if.err !== 1'b1) begin
            errors++;
            $display("FAIL rdpre_early_act: err=%b, required 1", bus_if.err);
        end
        act(7'd4);
        checks++;
        if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL rdpre_act_ok: err=%b busy=%b, required 0/1", bus_if.err, bus_if.busy);
        end
        nop(2);
        pre();
        nop(1);
    endtask

    task automatic test_unselected();
        issue(CMD_ACT, OTHER_CS, 1'b0, 7'd9, 3'd0, 1'b0);
        checks++;
        if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL unsel_act: err=%b busy=%b, required 0/0", bus_if.err, bus_if.busy);
        end
        issue(CMD_RDWR, OTHER_CS, 1'b1, 7'd0, 3'd0, 1'b0);
        checks++;
        if (bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL unsel_rd: err=%b, required 0", bus_if.err);
        end
        act(7'd3);
        nop(2);
        issue(CMD_ACT, OTHER_CS, 1'b0, 7'd8, 3'd0, 1'b0);
        issue(CMD_PRE, OTHER_CS, 1'b0, 7'd0, 3'd0, 1'b0);
        checks++;
        if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL unsel_active: err=%b busy=%b, required 0/0", bus_if.err, bus_if.busy);
        end
        wr(3'd4, 1'b1);
        checks++;
        if (bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL unsel_still_active: err=%b, required 0", bus_if.err);
        end
        rd(3'd4, 1'b1, 1'b1);
        nop(TCL);
        pre();
        nop(1);
    endtask

    task automatic test_reset_mid_read();
        act(7'd6);
        nop(2);
        wr(3'd0, 1'b1);
        rd(3'd0, 1'b0, 1'b0);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.rd_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: rd_valid=%b busy=%b err=%b, required 0/0/0",
                     bus_if.rd_valid, bus_if.busy, bus_if.err);
        end
        rst_b = 1'b1;
        rd(3'd0, 1'b0, 1'b0);
        checks++;
        if (bus_if.err !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle_rd: err=%b, required 1", bus_if.err);
        end
        nop(TCL + 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd_in_trcd();
        test_back_to_back();
        test_rd_then_pre();
        test_unselected();
        test_reset_mid_read();
        nop(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_bank_responder.md
# dram_bank_responder

Device-side model of one DRAM bank: the far end of the command interface driven by `dram_ctrl`. It decodes `cmd`/`cs`, keeps a single open row, enforces row-activate, CAS and precharge delays with counters, stores data in an internal array, and returns read data after a fixed CAS latency. Eight instances, one per `BANK_ID`, sit beside the controller in the system bench and in the integration top.

## Interface
- `DATA_WIDTH`, 1, width of one column word
- `NUM_OF_BANKS`, 8, number of banks; sets `cs` width
- `NUM_OF_ROWS`, 128, rows per bank
- `NUM_OF_COLS`, 8, columns per row
- `BANK_ID`, 0, value of `cs` this instance responds to
- `T_RCD`, 3, ACT-to-RD/WR delay in cycles (>=1)
- `T_CL`, 2, RD-to-data delay in cycles (>=1)
- `T_RP`, 2, PRE-to-ACT delay in cycles (>=1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_b`  in  1  asynchronous, active-low reset
- `cmd`  in  2  00 NOP, 01 ACT, 10 RDWR, 11 PRE
- `cs`  in  $clog2(NUM_OF_BANKS)  bank select; command ignored unless `cs == BANK_ID`
- `rw`  in  1  qualifies RDWR: 1 read, 0 write
- `row_addr`  in  $clog2(NUM_OF_ROWS)  row, sampled on ACT
- `col_addr`  in  $clog2(NUM_OF_COLS)  column, sampled on RDWR
- `wr_data`  in  DATA_WIDTH  write data, sampled on RDWR with `rw=0`
- `rd_data`  out  DATA_WIDTH  read data, valid when `rd_valid`
- `rd_valid`  out  1  one-cycle pulse per accepted read
- `busy`  out  1  high while a tRCD or tRP counter is running
- `err`  out  1  one-cycle pulse: selected command illegal in current state

## Operation
- States: IDLE (precharged), ACTIVATING, ACTIVE, PRECHARGING.
- IDLE + ACT: latch `row_addr` as open row, load counter, go to ACTIVATING.
- ACTIVATING: counter expiry moves to ACTIVE; any selected non-NOP command → `err`, ignored.
- ACTIVE + RDWR read: array[open_row][col] captured the same cycle into the read delay line.
- ACTIVE + RDWR write: array[open_row][col] ← `wr_data` at end of cycle.
- ACTIVE + PRE: load counter, go to PRECHARGING. ACTIVE + ACT → `err`, open row unchanged.
- PRECHARGING: counter expiry → IDLE; any selected non-NOP → `err`.
- IDLE + PRE: silent no-op, no `err`. IDLE + RDWR → `err`.
- Unselected or NOP cycles never change state and never raise `err`.
- Reads in flight continue and deliver after PRE; delay line never stalls.
- Read after write to the same column in the next cycle returns the new data.
- Array contents are not reset; all control state is.

## Timing
- Reset values: state IDLE, `rd_data`=0, `rd_valid`=0, `busy`=0, `err`=0, delay line cleared; reset mid-read drops pending data.
- ACT accepted at cycle t: `busy`=1 cycles t+1..t+T_RCD-1 (none if T_RCD=1); first legal RDWR at t+T_RCD.
- RDWR read at cycle r: `rd_valid`=1 and `rd_data` driven at cycle r+T_CL only; `rd_data` returns to 0 otherwise.
- Back-to-back reads each cycle produce back-to-back `rd_valid` pulses, in order, with no bubbles.
- PRE at cycle p: `busy`=1 cycles p+1..p+T_RP-1; first legal ACT at p+T_RP.
- `err` asserts the cycle after the offending command, for one cycle.
- All outputs registered.

## Structure
- Shared package `dram_pkg`: cmd encodings (`CMD_NOP`, `CMD_ACT`, `CMD_RDWR`, `CMD_PRE`), bank state enum, default timing constants; `dram_ctrl` imports the same encodings.
- Sub-module `dram_rd_pipe`: T_CL-deep valid+data shift register, parameterized by `DATA_WIDTH` and `T_CL`.
- State machine, counters and array remain in the top module.

## Test plan
- Reset, then ACT row 5 at t=0, WR col 3 data 1 at t=3, RD col 3 at t=4 → `rd_valid`=1, `rd_data`=1 at t=6; `busy` high t=1..2.
- RD issued at t=1 (inside tRCD) → `err` pulse at t=2, no `rd_valid` ever.
- Open row 7, write cols 0..7 alternating 1/0, eight consecutive RDs → eight consecutive `rd_valid` with 1,0,1,0,...
- RD at cycle r, PRE at r+1 → data still delivered at r+2; ACT at r+2 → `err`; ACT at r+3 accepted.
- Commands with `cs`=BANK_ID+1 (ACT, RDWR, PRE) → no state change, no `err`, no `rd_valid`.
- Assert `rst_b` low one cycle after a RD → `rd_valid` stays 0, state IDLE, subsequent RD → `err`.
